// File: rtl/posit_pkg.sv
// Shared constants and field bundles for the posit(64,4) -> binary64 path.
// Included by the decoder-side and FP64-side blocks alike.
package posit_pkg;

  localparam int POSIT_N   = 64;
  localparam int POSIT_ES  = 4;
  localparam int FP64_BIAS = 1023;

  localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;

  // Decoded posit as produced by the posit field decoder.
  typedef struct packed {
    logic        sign;
    logic [6:0]  regi;
    logic [3:0]  expo;
    logic [56:0] frac;
    logic        allone;
    logic        allzero;
  } posit_dec_t;

  // Fields held between the two pipeline stages.
  typedef struct packed {
    logic        sign;
    logic [10:0] bexp;
    logic [51:0] mant;
    logic        inc;
    logic        inexact;
    logic        allone;
    logic        allzero;
  } fp64_fields_t;

endpackage

// File: rtl/fp64_round_pack.sv
// Stage-2 combinational logic: applies the rounding increment and packs the
// binary64 word, with NaR and zero overriding the arithmetic result.
module fp64_round_pack
  import posit_pkg::*;
(
  input  fp64_fields_t f,
  output logic [63:0]  data,
  output logic         inexact,
  output logic         nar
);

  // A mantissa carry ripples into the exponent; the top biased exponent is
  // 2030, so the worst case (2031) stays finite.
  logic [62:0] mag;
  assign mag = {f.bexp, f.mant} + {62'd0, f.inc};

  always_comb begin
    data    = {f.sign, mag};
    inexact = f.inexact;
    nar     = 1'b0;
    if (f.allone) begin
      data    = FP64_QNAN;
      inexact = 1'b0;
      nar     = 1'b1;
    end else if (f.allzero) begin
      data    = 64'd0;
      inexact = 1'b0;
    end
  end

endmodule

// File: rtl/posit64_to_fp64.sv
// Two-stage posit(64,4) decoded-field to IEEE-754 binary64 converter with
// full valid/ready backpressure and round-to-nearest-even (or truncation).
module posit64_to_fp64
  import posit_pkg::*;
#(
  parameter int ES        = 4,
  parameter int FRAC_W    = 57,
  parameter int REG_W     = 7,
  parameter int ROUND_RTZ = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [REG_W-1:0]  in_regi,
  input  logic [ES-1:0]     in_expo,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_allone,
  input  logic              in_allzero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_inexact,
  output logic              out_nar
);

  if (ES != POSIT_ES || FRAC_W != 57 || REG_W != 7) begin : g_param_check
    $error("posit64_to_fp64 supports only ES=4, FRAC_W=57, REG_W=7");
  end

  localparam logic RNE = (ROUND_RTZ == 0);

  posit_dec_t   in_dec;
  fp64_fields_t s1_d;
  fp64_fields_t s1_q;
  logic         s1_valid;
  logic         s1_adv;
  logic [10:0]  scale;
  logic         guard;
  logic         sticky;
  logic [63:0]  pack_data;
  logic         pack_inexact;
  logic         pack_nar;

  assign in_dec = '{sign: in_sign, regi: in_regi, expo: in_expo, frac: in_frac,
                    allone: in_allone, allzero: in_allzero};

  // Handshake: a transfer happens on valid & ready at either end. The output
  // register holds while out_valid & ~out_ready; stage 1 moves forward when
  // the output register is empty or draining, and the input side is ready
  // when stage 1 is empty or moving. in_ready never depends on in_valid.
  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s1_adv;

  // scale = 16*r + e in 11-bit two's complement; +1023 lands in 15..2030.
  assign scale  = {in_dec.regi, 4'b0000} + {7'd0, in_dec.expo};
  assign guard  = in_dec.frac[4];
  assign sticky = |in_dec.frac[3:0];

  always_comb begin
    s1_d         = '0;
    s1_d.sign    = in_dec.sign;
    s1_d.bexp    = scale + 11'(FP64_BIAS);
    s1_d.mant    = in_dec.frac[56:5];
    s1_d.inc     = RNE & guard & (sticky | in_dec.frac[5]);
    s1_d.inexact = guard | sticky;
    s1_d.allone  = in_dec.allone;
    s1_d.allzero = in_dec.allzero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  fp64_round_pack u_round_pack (
    .f       (s1_q),
    .data    (pack_data),
    .inexact (pack_inexact),
    .nar     (pack_nar)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= 64'd0;
      out_inexact <= 1'b0;
      out_nar     <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= pack_data;
        out_inexact <= pack_inexact;
        out_nar     <= pack_nar;
      end
    end
  end

endmodule

// File: doc/posit64_to_fp64.md
Name: posit64_to_fp64

Overview:
- Pipelined converter that consumes the decoded fields of a 64-bit posit (es=4) from the posit field decoder and produces an IEEE-754 binary64 word.
- Sits directly downstream of the decoder, in a valid/ready stream toward the FP64 interface.
- Has a two-stage pipeline with full backpressure and rounds to 52 mantissa bits.

Parameters:
- ES, 4: posit exponent field width; fixed, and the block is checked at elaboration for ES=4.
- FRAC_W, 57: decoded fraction width; the hidden 1 is implicit.
- REG_W, 7: signed regime width (two's complement).
- ROUND_RTZ, 0: 0 = round-to-nearest-even; 1 = truncate.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded posit present.
- in_ready  out  1  stage 1 can accept.
- in_sign  in  1  sign of the original posit.
- in_regi  in  7  signed regime r, range -63..62.
- in_expo  in  4  unsigned exponent e.
- in_frac  in  57  fraction bits after the hidden 1, MSB first.
- in_allone  in  1  NaR flag.
- in_allzero  in  1  zero flag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_data  out  64  binary64 result.
- out_inexact  out  1  rounding discarded nonzero bits.
- out_nar  out  1  result is NaR-derived NaN.

Behaviour:
- Reset (async assert, sync release): both stage valids = 0, out_valid = 0, out_data = 0, out_inexact = 0, out_nar = 0. in_ready = 1 after reset.
- Value definition: (-1)^sign * 2^(16*r + e) * 1.frac.
  - Scale = 16*r + e is computed in 11-bit signed arithmetic and lies in -1008..1007.
  - Biased exponent = scale + 1023, range 15..2030, so the result is always normal: no overflow, no subnormals.
- Stage 1, on accept:
  - Register the sign and the biased exponent.
  - Register mant = frac[56:5], guard = frac[4], sticky = OR(frac[3:0]).
  - Compute inc = ~ROUND_RTZ & guard & (sticky | frac[5]).
  - Register the special flags.
- Stage 2, on advance:
  - Form {exp, mant} + inc as one 63-bit add; a mantissa carry propagates into the exponent (max 2031, still finite).
  - out_data = {sign, exp, mant}.
  - out_inexact = guard | sticky.
- Specials override arithmetic in stage 2:
  - allone: out_data = 64'h7FF8_0000_0000_0000, out_nar = 1, out_inexact = 0.
  - allzero: out_data = 64'h0, out_nar = 0, out_inexact = 0. The sign is ignored.
  - If allone and allzero are both set, allone wins.
- Handshake:
  - A transfer occurs on valid & ready.
  - s2 holds while out_valid & ~out_ready.
  - s1 advances when s2 is empty or draining: s1_adv = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s1_adv.
  - No combinational path from in_valid to in_ready.
  - out_data, out_inexact and out_nar remain stable while out_valid & ~out_ready.
- Latency and throughput: 2 cycles from input transfer to out_valid; one result per cycle sustained when out_ready = 1.
- Ordering: results leave in acceptance order, with no drops and no duplicates.
- Simultaneous events: a new input is accepted in the same cycle stage 2 drains; stage 1 refills in that same cycle.
- Reset mid-operation: in-flight entries are discarded and no partial output appears.

Decomposition:
- Shared package posit_pkg holds:
  - POSIT_N=64, POSIT_ES=4, FP64_BIAS=1023.
  - The canonical NaN constant 64'h7FF8_0000_0000_0000.
  - A decoded-posit struct {sign, regi, expo, frac, allone, allzero}.
- One natural sub-module: fp64_round_pack. It is the combinational stage-2 logic that takes the registered fields and produces out_data and the flags.

Test Plan:
- r=0, e=0, frac=0, sign=0 -> 64'h3FF0_0000_0000_0000 two cycles later, inexact=0. Same with sign=1 -> 64'hBFF0_0000_0000_0000.
- Extremes:
  - r=-1, e=15 -> 64'h3FE0_0000_0000_0000.
  - r=62, e=15 -> 64'h7EE0_0000_0000_0000.
  - r=-63, e=0 -> 64'h00F0_0000_0000_0000.
- Rounding with r=0, e=0:
  - frac=57'h10 (tie, even) -> 64'h3FF0_0000_0000_0000, inexact=1.
  - frac=57'h30 -> 64'h3FF0_0000_0000_0002.
  - frac=all ones -> 64'h4000_0000_0000_0000, inexact=1.
  - frac=57'h1 -> 64'h3FF0_0000_0000_0000, inexact=1.
  - frac=57'h10 with ROUND_RTZ=1 -> 64'h3FF0_0000_0000_0000.
- Specials:
  - allone=1 -> 64'h7FF8_0000_0000_0000, out_nar=1.
  - allzero=1 with sign=1 -> 64'h0.
  - Both flags set -> NaN.
- Backpressure:
  - Stream 10 back-to-back inputs with out_ready toggling in a 1-0-0-1 pattern.
  - Required: in_ready drops after 2 stalled entries, out_data stays stable while stalled, and all 10 results arrive in order.
- Reset mid-operation:
  - Assert rst with both stages full and out_ready=0.
  - Required: out_valid=0 immediately (async). After release, no stale output, and the first new input emerges in 2 cycles.
